// File: rtl/serial_inequality_comparator_pkg.sv
// rtl/serial_inequality_comparator_pkg.sv - shared types and constants for the serial inequality comparator
package serial_inequality_comparator_pkg;

    // Default operand width; the parallel comparator this cross-checks is 6 bits wide
    localparam int SIC_WIDTH = 6;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sic_state_e;

    // Bit-index width for a given operand width (never below 1 so the port stays legal)
    function automatic int sic_idx_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_inequality_comparator_bit_mismatch_cell.sv
// rtl/serial_inequality_comparator_bit_mismatch_cell.sv - single-bit XOR mismatch cell
module bit_mismatch_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic diff
);

    // The only datapath gate: one XOR shared by every bit position over time
    assign diff = a_bit ^ b_bit;

endmodule

// File: rtl/serial_inequality_comparator.sv
// rtl/serial_inequality_comparator.sv - bit-serial LSB-first inequality comparator with first-difference index
module serial_inequality_comparator
    import serial_inequality_comparator_pkg::*;
#(
    parameter int WIDTH = SIC_WIDTH,
    parameter int IDXW  = sic_idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             desigual,
    output logic [IDXW-1:0]  first_diff_idx
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    sic_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic             desigual_q, desigual_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             bit_diff;

    // Compare the current LSBs of the captured operands
    bit_mismatch_cell u_cell (
        .a_bit (sa_q[0]),
        .b_bit (sb_q[0]),
        .diff  (bit_diff)
    );

    // State register; reset aborts any scan in flight without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: shifted operands, bit counter and held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q       <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            desigual_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            desigual_q <= desigual_d;
            idx_q      <= idx_d;
        end
    end

    // Next-state and datapath update; start is only honoured outside SCAN
    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        desigual_d = desigual_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d       = a;
                    sb_d       = b;
                    cnt_d      = '0;
                    desigual_d = 1'b0;
                    idx_d      = '0;
                    state_d    = ST_SCAN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bit_diff) begin
                    desigual_d = 1'b1;
                    idx_d      = cnt_q;
                    state_d    = ST_DONE;
                end else if (cnt_q == LAST_IDX) begin
                    desigual_d = 1'b0;
                    idx_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    sa_d       = sa_q >> 1;
                    sb_d       = sb_q >> 1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: handshake flags decode straight from state, result from held registers
    always_comb begin
        busy           = (state_q == ST_SCAN);
        done           = (state_q == ST_DONE);
        desigual       = desigual_q;
        first_diff_idx = idx_q;
    end

endmodule

// File: tb/tb_serial_inequality_comparator.sv
// tb/tb_serial_inequality_comparator.sv - self-checking bench for the serial inequality comparator
module tb_serial_inequality_comparator;

    localparam int W  = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic          desigual;
    logic [IW-1:0] first_diff_idx;

    int tests = 0;
    int fails = 0;

    serial_inequality_comparator #(.WIDTH(W), .IDXW(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .done           (done),
        .desigual       (desigual),
        .first_diff_idx (first_diff_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: lowest index where the words differ, -1 when equal
    function automatic int ref_first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = 0; i < W; i++) begin
            if (d[i]) return i;
        end
        return -1;
    endfunction

    // Present operands with start and let one rising edge accept them
    task automatic launch(input logic [W-1:0] na, input logic [W-1:0] nb);
        a = na;
        b = nb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called right after launch; follows the scan to done and checks against the model
    task automatic wait_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input bit noise);
        int fd;
        int lat;
        int busy_n;
        int exp_lat;
        int exp_busy;
        fd       = ref_first_diff(ea, eb);
        exp_lat  = (fd < 0) ? W + 1 : fd + 2;
        exp_busy = (fd < 0) ? W : fd + 1;
        lat      = 1;
        busy_n   = 0;
        check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        while (!done && lat < 50) begin
            if (busy) busy_n++;
            if (noise && busy) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_desigual"}, 32'(desigual), (fd >= 0) ? 32'd1 : 32'd0);
        check({tag, "_idx"}, 32'(first_diff_idx), (fd >= 0) ? 32'(fd) : 32'd0);
    endtask

    // One cycle after done with no start: pulse ends, result held
    task automatic check_hold(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
        int fd;
        fd = ref_first_diff(ea, eb);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_desigual_held"}, 32'(desigual), (fd >= 0) ? 32'd1 : 32'd0);
        check({tag, "_idx_held"}, 32'(first_diff_idx), (fd >= 0) ? 32'(fd) : 32'd0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input bit noise);
        @(negedge clk);
        launch(ra, rb);
        wait_result(tag, ra, rb, noise);
        check_hold(tag, ra, rb);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit saw_done;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_desigual", 32'(desigual), 32'd0);
        check("rst_idx", 32'(first_diff_idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run("eq",    6'b000110, 6'b000110, 1'b0);
        run("lsb",   6'b101011, 6'b101010, 1'b0);
        run("msb",   6'b100000, 6'b000000, 1'b0);
        run("bit3",  6'b001000, 6'b000000, 1'b0);

        // Async reset while idle clears a held nonzero result
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("idle_rst_desigual", 32'(desigual), 32'd0);
        check("idle_rst_idx", 32'(first_diff_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start and operand churn during SCAN is ignored
        @(negedge clk);
        launch(6'b000000, 6'b111111);
        wait_result("busy_start", 6'b000000, 6'b111111, 1'b1);
        check_hold("busy_start", 6'b000000, 6'b111111);
        run("busy_start_msb", 6'b100000, 6'b000000, 1'b1);

        // Back-to-back: start held in the DONE cycle
        @(negedge clk);
        launch(6'b010100, 6'b000100);
        wait_result("b2b_first", 6'b010100, 6'b000100, 1'b0);
        launch(6'b111111, 6'b111111);
        wait_result("b2b_second", 6'b111111, 6'b111111, 1'b0);
        check_hold("b2b_second", 6'b111111, 6'b111111);

        // Async reset mid-scan aborts with no done pulse
        @(negedge clk);
        launch(6'b100000, 6'b000000);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_desigual", 32'(desigual), 32'd0);
        check("abort_idx", 32'(first_diff_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run("after_abort", 6'b000000, 6'b010000, 1'b0);

        // Randomized operands: equal, single-bit flip, or independent
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run($sformatf("rnd%0d", n), ra, rb, 1'(n % 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_inequality_comparator.md
Name: serial_inequality_comparator

Overview:
Bit-serial counterpart of the team's parallel 6-bit inequality comparator. It accepts two WIDTH-bit words on a start handshake and scans them one bit per clock, LSB first, through a single XOR mismatch cell. It stops at the first differing bit and reports the desigual flag plus the index of that bit. It is used where gate count matters more than latency, and as a cross-check against the parallel comparator.

Parameters:
WIDTH, 6, operand width in bits (minimum 2)
IDXW, $clog2(WIDTH), width of the bit-index output (3 for WIDTH=6)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a comparison; sampled only while busy=0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while scanning; start is ignored while high
done  output  1  one-cycle pulse when the result is valid
desigual  output  1  1 if the operands differ in any bit; held until the next accepted start
first_diff_idx  output  IDXW  index of the lowest differing bit; 0 when the operands are equal; held

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- While rst=1, the FSM is forced to IDLE and every output is 0: busy, done, desigual, first_diff_idx. Shift registers and the bit counter are also cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1, capture a→sa and b→sb, clear desigual and first_diff_idx, set cnt=0, go to SCAN.
- SCAN:
  - busy=1. Each cycle, compare sa[0] with sb[0] through the mismatch cell.
  - On mismatch: desigual←1, first_diff_idx←cnt, go to DONE.
  - On match with cnt==WIDTH-1: desigual←0, first_diff_idx←0, go to DONE.
  - Otherwise shift sa and sb right by 1, cnt←cnt+1, stay in SCAN.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - If start=1, perform the same capture as in IDLE and go directly to SCAN (back-to-back operation). Otherwise go to IDLE.
- Latency: with start accepted at edge k, done is high in cycle k+2+i, where i is the first differing index. Equal operands give done in cycle k+1+WIDTH, i.e. 7 cycles for WIDTH=6.
- start asserted while busy=1 is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- Changes on a and b after capture have no effect on the result.
- rst asserted mid-SCAN aborts the operation immediately. No done pulse is produced, and the outputs return to 0.
- desigual and first_diff_idx change only at capture (cleared) or at the SCAN→DONE transition.
- cnt never exceeds WIDTH-1; there is no wrap-around.

Decomposition:
- Shared package: state enum (IDLE, SCAN, DONE), default WIDTH=6 constant, IDXW derivation.
- One sub-module, bit_mismatch_cell: a single XOR producing the 1-bit difference. It is the only datapath logic and is instantiated once.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset, then a=000110, b=000110, start pulse → busy high 6 cycles; done pulse 7 cycles after the accepting edge; desigual=0; first_diff_idx=0.
- a=101011, b=101010 → done 2 cycles after start; desigual=1; first_diff_idx=0.
- a=100000, b=000000 → done 7 cycles after start; desigual=1; first_diff_idx=5. Then a=001000, b=000000 → done after 5 cycles; first_diff_idx=3.
- Start a=000000, b=111111 and, during SCAN, pulse start with a=b=000000 and toggle a/b → ignored; result desigual=1, first_diff_idx=0.
- Back-to-back: start held high in the DONE cycle with a=111111, b=111111 → busy re-asserts next cycle; second done after 7 cycles with desigual=0.
- a=100000, b=000000; assert rst asynchronously at cycle 3 of SCAN → all outputs 0 immediately; no done pulse; next start completes normally.
